// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: sequencing controller for the Sobel 3x3 datapath.
//
// Tracks the column/row position of the incoming pixel stream from the
// h_sync/v_sync markers. It rotates the write buffer across three line-buffer
// RAMs and drives their shared column address. It also flags when a complete
// 3x3 window is present for the convolution stage.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   h_sync            line-start marker (pixel sampled with it is column 0)
//   v_sync            frame-start marker, only meaningful together with h_sync
//   lb_wr_en          write strobe for the current line buffer
//   lb_wr_sel         buffer being written (0..2)
//   lb_top_sel        buffer holding row r-2
//   lb_mid_sel        buffer holding row r-1
//   lb_addr           column address shared by the write and both reads
//   col, row          position of the pixel sampled on the previous edge
//   win_valid         full 3x3 window centred at (row-1, col-1)
//   frame_done        one-cycle pulse after the last active pixel of a frame
//   err_short         one-cycle pulse when a line ends before IMG_W pixels
//
// Every output is registered and describes the pixel sampled on the previous
// clock edge. The datapath delays its pixel by one register to stay aligned.
// Reads and the write share one address, so the RAMs must be read-first.

module sobel_window_ctrl #(
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              h_sync,
  input  logic              v_sync,
  output logic              lb_wr_en,
  output logic [1:0]        lb_wr_sel,
  output logic [1:0]        lb_top_sel,
  output logic [1:0]        lb_mid_sel,
  output logic [ADDR_W-1:0] lb_addr,
  output logic [ADDR_W-1:0] col,
  output logic [7:0]        row,
  output logic              win_valid,
  output logic              frame_done,
  output logic              err_short
);

  localparam int unsigned ROW_W = 8;
  localparam int unsigned SEL_W = 2;

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX  = '1;
  localparam logic [ADDR_W-1:0] WIN_COL  = ADDR_W'(2);
  localparam logic [ROW_W-1:0]  WIN_ROW  = ROW_W'(2);

  typedef enum logic [1:0] {
    ST_WAIT_FRAME = 2'd0,
    ST_LINE       = 2'd1,
    ST_WAIT_LINE  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   col_nxt;
  logic [ROW_W-1:0]    row_nxt;
  logic [SEL_W-1:0]    sel_nxt;
  logic                frame_done_nxt;
  logic                err_short_nxt;
  logic                last_col;
  logic                last_row;
  logic                in_line;

  // Modulo-3 increment used for buffer rotation and the read-select mapping.
  function automatic logic [SEL_W-1:0] inc_mod3(input logic [SEL_W-1:0] s);
    return (s == SEL_W'(2)) ? SEL_W'(0) : s + SEL_W'(1);
  endfunction

  assign in_line  = (state == ST_LINE);
  assign last_col = (col == LAST_COL);
  // Short lines still count as rows, so a frame may run past IMG_H-1 rows.
  assign last_row = (row >= LAST_ROW);

  // Next position/state for the pixel being sampled on this edge.
  always_comb begin
    state_nxt      = state;
    col_nxt        = col;
    row_nxt        = row;
    sel_nxt        = lb_wr_sel;
    frame_done_nxt = 1'b0;
    err_short_nxt  = 1'b0;

    case (state)
      ST_WAIT_FRAME: begin
        state_nxt = ST_WAIT_FRAME;
      end
      ST_LINE: begin
        if (last_col) begin
          // Line complete; the final line of the frame ends the frame.
          frame_done_nxt = last_row;
          state_nxt      = last_row ? ST_WAIT_FRAME : ST_WAIT_LINE;
        end else begin
          col_nxt = col + ADDR_W'(1);
        end
      end
      ST_WAIT_LINE: begin
        state_nxt = ST_WAIT_LINE;
      end
      default: begin
        state_nxt = ST_WAIT_FRAME;
      end
    endcase

    if (h_sync && v_sync) begin
      // Frame (re)start is honoured from any state.
      state_nxt     = ST_LINE;
      col_nxt       = '0;
      row_nxt       = '0;
      sel_nxt       = '0;
      err_short_nxt = in_line && !last_col;
    end else if (h_sync && state_nxt != ST_WAIT_FRAME) begin
      // Line start; ignored while waiting for a frame or at end of frame.
      state_nxt     = ST_LINE;
      col_nxt       = '0;
      row_nxt       = (row == ROW_MAX) ? row : row + ROW_W'(1);
      sel_nxt       = inc_mod3(lb_wr_sel);
      err_short_nxt = in_line && !last_col;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_WAIT_FRAME;
      col        <= '0;
      row        <= '0;
      lb_wr_sel  <= SEL_W'(0);
      lb_top_sel <= SEL_W'(1);
      lb_mid_sel <= SEL_W'(2);
      lb_wr_en   <= 1'b0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      err_short  <= 1'b0;
    end else begin
      state      <= state_nxt;
      col        <= col_nxt;
      row        <= row_nxt;
      lb_wr_sel  <= sel_nxt;
      lb_top_sel <= inc_mod3(sel_nxt);
      lb_mid_sel <= inc_mod3(inc_mod3(sel_nxt));
      lb_wr_en   <= (state_nxt == ST_LINE);
      win_valid  <= (state_nxt == ST_LINE) && (row_nxt >= WIN_ROW) &&
                    (col_nxt >= WIN_COL);
      frame_done <= frame_done_nxt;
      err_short  <= err_short_nxt;
    end
  end

  // Write and both reads always target the current column.
  assign lb_addr = col;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Testbench for sobel_window_ctrl: table-driven directed vectors plus a
// line/frame generator; expected outputs are queued at drive time and
// compared one cycle later when the DUT presents them.

module tb_sobel_window_ctrl;

  localparam int unsigned IMG_W  = 32;
  localparam int unsigned IMG_H  = 32;
  localparam int unsigned ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              h_sync;
  logic              v_sync;
  logic              lb_wr_en;
  logic [1:0]        lb_wr_sel;
  logic [1:0]        lb_top_sel;
  logic [1:0]        lb_mid_sel;
  logic [ADDR_W-1:0] lb_addr;
  logic [ADDR_W-1:0] col;
  logic [7:0]        row;
  logic              win_valid;
  logic              frame_done;
  logic              err_short;

  sobel_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .lb_wr_en   (lb_wr_en),
    .lb_wr_sel  (lb_wr_sel),
    .lb_top_sel (lb_top_sel),
    .lb_mid_sel (lb_mid_sel),
    .lb_addr    (lb_addr),
    .col        (col),
    .row        (row),
    .win_valid  (win_valid),
    .frame_done (frame_done),
    .err_short  (err_short)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              wr_en;
    logic [1:0]        wr_sel;
    logic [1:0]        top_sel;
    logic [1:0]        mid_sel;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] col;
    logic [7:0]        row;
    logic              win;
    logic              fd;
    logic              es;
  } obs_t;

  typedef struct {
    logic  r;
    logic  h;
    logic  v;
    obs_t  e;
    string tag;
  } vec_t;

  // Read-select mapping per write select: 0->(1,2), 1->(2,0), 2->(0,1).
  logic [1:0] top_of [3];
  logic [1:0] mid_of [3];

  obs_t  sb_q [$];
  string tag_q [$];
  int    checks   = 0;
  int    failures = 0;
  int    win_cnt  = 0;
  int    fd_cnt   = 0;
  bit    count_en = 1'b0;
  obs_t  rst_exp;
  vec_t  tbl [13];

  function automatic obs_t mk(input bit en, input int sel, input int c,
                              input int r, input bit fd, input bit es);
    obs_t o;
    o.wr_en   = en;
    o.wr_sel  = 2'(sel);
    o.top_sel = top_of[sel];
    o.mid_sel = mid_of[sel];
    o.addr    = ADDR_W'(c);
    o.col     = ADDR_W'(c);
    o.row     = 8'(r);
    o.win     = en && (r >= 2) && (c >= 2);
    o.fd      = fd;
    o.es      = es;
    return o;
  endfunction

  function automatic vec_t mkv(input logic r, input logic h, input logic v,
                               input obs_t e, input string tag);
    vec_t x;
    x.r = r; x.h = h; x.v = v; x.e = e; x.tag = tag;
    return x;
  endfunction

  task automatic step(input logic r, input logic h, input logic v,
                      input obs_t e, input string tag);
    @(negedge clk);
    rst    = r;
    h_sync = h;
    v_sync = v;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // One line of npix pixels followed by gap blanking cycles. hs_gap places a
  // stray h_sync in the gap (only used where it must be ignored).
  task automatic send_line(input int npix, input int gap, input bit vs,
                           input int r, input int sel, input bit es_first,
                           input bit fd_after, input int hs_gap);
    for (int i = 0; i < npix; i++)
      step(1'b0, i == 0, (i == 0) && vs,
           mk(1'b1, sel, i, r, 1'b0, (i == 0) && es_first),
           $sformatf("px_r%0d_c%0d", r, i));
    for (int g = 0; g < gap; g++)
      step(1'b0, g == hs_gap, 1'b0,
           mk(1'b0, sel, npix - 1, r, (g == 0) && fd_after, 1'b0),
           $sformatf("gap_r%0d_g%0d", r, g));
  endtask

  task automatic monitor();
    obs_t  got;
    obs_t  want;
    string tag;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        want = sb_q.pop_front();
        tag  = tag_q.pop_front();
        got  = {lb_wr_en, lb_wr_sel, lb_top_sel, lb_mid_sel, lb_addr, col,
                row, win_valid, frame_done, err_short};
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL %s: got en=%b sel=%0d top=%0d mid=%0d addr=%0d col=%0d row=%0d win=%b fd=%b es=%b; want en=%b sel=%0d top=%0d mid=%0d addr=%0d col=%0d row=%0d win=%b fd=%b es=%b",
                   tag, got.wr_en, got.wr_sel, got.top_sel, got.mid_sel,
                   got.addr, got.col, got.row, got.win, got.fd, got.es,
                   want.wr_en, want.wr_sel, want.top_sel, want.mid_sel,
                   want.addr, want.col, want.row, want.win, want.fd, want.es);
        end
      end
      if (count_en) begin
        if (win_valid === 1'b1)  win_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
      end
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 8 && sb_q.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL %s: got %0d pending expectations, want 0", tag, sb_q.size());
      sb_q.delete();
      tag_q.delete();
    end
  endtask

  initial begin
    rst    = 1'b1;
    h_sync = 1'b0;
    v_sync = 1'b0;
    top_of = '{2'd1, 2'd2, 2'd0};
    mid_of = '{2'd2, 2'd0, 2'd1};
    rst_exp = mk(1'b0, 0, 0, 0, 1'b0, 1'b0);

    fork
      monitor();
    join_none

    // Directed vectors: reset, ignored syncs, read-select rotation, restarts.
    tbl[0]  = mkv(1'b1, 1'b0, 1'b0, rst_exp, "reset");
    tbl[1]  = mkv(1'b0, 1'b1, 1'b0, rst_exp, "hs_ignored_idle");
    tbl[2]  = mkv(1'b0, 1'b0, 1'b1, rst_exp, "vs_alone_ignored");
    tbl[3]  = mkv(1'b0, 1'b0, 1'b0, rst_exp, "idle");
    tbl[4]  = mkv(1'b1, 1'b1, 1'b1, rst_exp, "reset_beats_sync");
    tbl[5]  = mkv(1'b0, 1'b1, 1'b1, mk(1'b1, 0, 0, 0, 1'b0, 1'b0), "frame_start_sel0");
    tbl[6]  = mkv(1'b0, 1'b0, 1'b0, mk(1'b1, 0, 1, 0, 1'b0, 1'b0), "col1");
    tbl[7]  = mkv(1'b0, 1'b1, 1'b0, mk(1'b1, 1, 0, 1, 1'b0, 1'b1), "short_sel1");
    tbl[8]  = mkv(1'b0, 1'b1, 1'b0, mk(1'b1, 2, 0, 2, 1'b0, 1'b1), "short_sel2");
    tbl[9]  = mkv(1'b0, 1'b0, 1'b0, mk(1'b1, 2, 1, 2, 1'b0, 1'b0), "r2c1_nowin");
    tbl[10] = mkv(1'b0, 1'b0, 1'b0, mk(1'b1, 2, 2, 2, 1'b0, 1'b0), "r2c2_win");
    tbl[11] = mkv(1'b0, 1'b1, 1'b1, mk(1'b1, 0, 0, 0, 1'b0, 1'b1), "vs_interrupt");
    tbl[12] = mkv(1'b1, 1'b0, 1'b0, rst_exp, "reset_midline");
    for (int i = 0; i < 13; i++)
      step(tbl[i].r, tbl[i].h, tbl[i].v, tbl[i].e, tbl[i].tag);
    drain("table_drain");

    // Nominal frame: h_sync every 64 cycles, stray h_sync after frame end.
    count_en = 1'b1;
    for (int r = 0; r < int'(IMG_H); r++)
      send_line(IMG_W, 32, r == 0, r, r % 3, 1'b0, r == int'(IMG_H) - 1,
                (r == int'(IMG_H) - 1) ? 10 : -1);
    drain("frame1_drain");
    count_en = 1'b0;
    checks++;
    if (win_cnt != 900) begin
      failures++;
      $display("FAIL win_valid_count: got %0d want 900", win_cnt);
    end
    checks++;
    if (fd_cnt != 1) begin
      failures++;
      $display("FAIL frame_done_count: got %0d want 1", fd_cnt);
    end

    // Second frame: short row 5, mid-frame restarts, reset at row 10 col 15.
    for (int r = 0; r < 5; r++)
      send_line(IMG_W, 32, r == 0, r, r % 3, 1'b0, 1'b0, -1);
    send_line(20, 0, 1'b0, 5, 2, 1'b0, 1'b0, -1);
    for (int r = 6; r < 17; r++)
      send_line(IMG_W, 32, 1'b0, r, r % 3, r == 6, 1'b0, -1);
    send_line(IMG_W, 32, 1'b1, 0, 0, 1'b0, 1'b0, -1);
    send_line(IMG_W, 32, 1'b0, 1, 1, 1'b0, 1'b0, -1);
    send_line(10, 0, 1'b0, 2, 2, 1'b0, 1'b0, -1);
    send_line(IMG_W, 32, 1'b1, 0, 0, 1'b1, 1'b0, -1);
    for (int r = 1; r < 10; r++)
      send_line(IMG_W, 32, 1'b0, r, r % 3, 1'b0, 1'b0, -1);
    send_line(16, 0, 1'b0, 10, 1, 1'b0, 1'b0, -1);
    step(1'b1, 1'b0, 1'b0, rst_exp, "reset_r10c15");
    step(1'b0, 1'b1, 1'b0, rst_exp, "post_rst_hs_a");
    step(1'b0, 1'b0, 1'b0, rst_exp, "post_rst_idle_a");
    step(1'b0, 1'b0, 1'b0, rst_exp, "post_rst_idle_b");
    step(1'b0, 1'b1, 1'b0, rst_exp, "post_rst_hs_b");
    step(1'b0, 1'b0, 1'b1, rst_exp, "post_rst_vs_alone");
    step(1'b0, 1'b0, 1'b0, rst_exp, "post_rst_idle_c");
    drain("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_window_ctrl.md
# sobel_window_ctrl

Sequencing controller for the Sobel 3x3 datapath. It tracks column and row position in the incoming 8-bit pixel stream using the `h_sync`/`v_sync` markers. It rotates write and read selection across three line-buffer RAMs, drives their shared address, and tells the convolution stage when a complete 3x3 window is present. It sits between the pixel source and the line buffers / Sobel kernel in `top_level`.

## Interface
- `IMG_W`, 32, active pixels per line
- `IMG_H`, 32, active lines per frame
- `ADDR_W`, 5, line-buffer address width; `2**ADDR_W >= IMG_W`

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `h_sync`  in  1  one-cycle line-start marker; the pixel sampled in the same cycle is column 0
- `v_sync`  in  1  one-cycle frame-start marker; only valid together with `h_sync`; marks row 0
- `lb_wr_en`  out  1  write strobe for the current line buffer
- `lb_wr_sel`  out  2  buffer being written (0,1,2)
- `lb_top_sel`  out  2  buffer holding row r-2
- `lb_mid_sel`  out  2  buffer holding row r-1
- `lb_addr`  out  ADDR_W  column address, shared by write and both reads
- `col`  out  ADDR_W  current column
- `row`  out  8  current row
- `win_valid`  out  1  a full 3x3 window is available, centred at (row-1, col-1)
- `frame_done`  out  1  one-cycle pulse after the last active pixel of the frame
- `err_short`  out  1  one-cycle pulse when a line ends with fewer than `IMG_W` pixels

## Operation
- States:
  - WAIT_FRAME: the reset state.
  - LINE: receiving active pixels.
  - WAIT_LINE: the line is complete and the block waits for the next `h_sync`.
- Transitions:
  - WAIT_FRAME -> LINE on `v_sync & h_sync`.
  - LINE -> WAIT_LINE after column `IMG_W-1`.
  - WAIT_LINE -> LINE on `h_sync`.
  - From the last pixel of row `IMG_H-1`, go to WAIT_FRAME instead of WAIT_LINE and pulse `frame_done`.
- `h_sync` without `v_sync` in WAIT_FRAME is ignored.
- Line start (`h_sync` accepted):
  - col=0.
  - row increments, or is set to 0 if `v_sync` is high.
  - `lb_wr_sel` advances mod 3, or is set to 0 if `v_sync` is high.
- Read selects are fixed functions of the write select:
  - `lb_top_sel = (lb_wr_sel+1) mod 3`
  - `lb_mid_sel = (lb_wr_sel+2) mod 3`
- `lb_wr_en`: high for every pixel in LINE, low in WAIT_LINE and WAIT_FRAME. Pixels arriving in WAIT_LINE are dropped.
- `win_valid` = LINE & row>=2 & col>=2. This gives (IMG_W-2)*(IMG_H-2) windows per frame.
- Boundary cases:
  - `h_sync` during LINE before col `IMG_W-1`: pulse `err_short`, then start the new line as normal; the short line still counts as a row.
  - `v_sync & h_sync` in any state: restart the frame at row 0, `lb_wr_sel` 0. If this interrupts LINE, also pulse `err_short`.
  - `v_sync` without `h_sync`: ignored.
  - `rst` at any time, including mid-line: return to WAIT_FRAME with all outputs at reset values.
- Row counter saturates at 255.

## Timing
- All outputs are registered and reflect the pixel sampled on the previous clock edge, so latency is 1 cycle from `h_sync`/pixel sample to `lb_addr`/`lb_wr_en`/`win_valid`. The datapath delays its pixel by one register to stay aligned.
- `lb_addr == col` in every cycle. Reads and write target the same address; the RAMs must be read-first.
- `frame_done` and `err_short` are high for exactly 1 cycle.
- Reset values: state WAIT_FRAME, `lb_wr_sel`=0, `lb_top_sel`=1, `lb_mid_sel`=2. Every other output is 0: `lb_wr_en`, `lb_addr`, `col`, `row`, `win_valid`, `frame_done`, `err_short`.

## Test plan
- **Nominal frame.** 32x32 stream with `h_sync` every 64 cycles and `v_sync` on the first line.
  - 900 `win_valid` cycles.
  - `lb_wr_sel` sequence 0,1,2,0,... per line.
  - Exactly 1 `frame_done`, one cycle after the pixel at (31,31).
- **Blanking gap.** The 32 cycles between lines have `lb_wr_en`=0 and `win_valid`=0; the pixels arriving there are not written.
- **Short line.** `h_sync` issued after 20 pixels of row 5.
  - `err_short` pulses once.
  - Row 6 starts at col 0.
  - `lb_wr_sel` advances.
- **Mid-frame `v_sync`.** `v_sync & h_sync` at row 17: row=0, `lb_wr_sel`=0, and no `win_valid` for the next two lines.
- **Reset.** `rst` asserted at row 10, col 15: the next cycle shows all outputs at reset values, and subsequent `h_sync` pulses without `v_sync` are ignored.
- **Read selects.** For each `lb_wr_sel` value 0/1/2, check (`lb_top_sel`, `lb_mid_sel`) = (1,2)/(2,0)/(0,1).
